// File: rtl/sha256_padder_if.sv
// Message word stream in, padded 512-bit blocks out to sha256_engine.
interface sha256_padder_if;
  logic [31:0]  din_i;
  logic         din_valid_i;
  logic         din_last_i;
  logic [2:0]   din_bytes_i;
  logic         din_ready_o;
  logic         eng_ready_i;
  logic         eng_start_o;
  logic [511:0] eng_vec_o;
  logic         eng_last_o;
  logic         busy_o;

  modport slave (
    input  din_i, din_valid_i, din_last_i, din_bytes_i, eng_ready_i,
    output din_ready_o, eng_start_o, eng_vec_o, eng_last_o, busy_o
  );

  modport master (
    output din_i, din_valid_i, din_last_i, din_bytes_i, eng_ready_i,
    input  din_ready_o, eng_start_o, eng_vec_o, eng_last_o, busy_o
  );
endinterface

// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs 32-bit words into 512-bit blocks with 0x80 / zero / length padding.
// Optional SHA256_PAD_BYTESWAP_EN: input words are little-endian (first byte in [7:0]).
// state | meaning: FILL accept payload | PAD0 place 0x80000000 | PADZ zero/length fill
//       | ISSUE start pulse | WAIT_LO engine took block | WAIT_HI engine done
module sha256_padder #(
  parameter int LEN_W = 64
) (
  input  logic          clk_100mhz,
  input  logic          rst_i,
  sha256_padder_if.slave bus
);

  typedef enum logic [2:0] {
    S_FILL, S_PAD0, S_PADZ, S_ISSUE, S_WAIT_LO, S_WAIT_HI
  } state_t;

  typedef enum logic [1:0] {
    A_FILL, A_PAD0, A_PADZ, A_DONE
  } after_t;

  state_t             r_state;
  state_t             w_state_nxt;
  after_t             r_after;
  logic [4:0]         r_idx;
  logic [LEN_W-1:0]   r_bitlen;
  logic [31:0]        r_words [16];
  logic               r_last;
  logic               r_busy;
  logic               r_din_ready;
  logic               r_len_here;
  logic               w_start;
  logic               w_accept;
  logic [31:0]        w_word;
  logic [2:0]         w_bytes_sat;
  logic [4:0]         w_shift;
  logic [31:0]        w_pad_word;
  logic [31:0]        w_store;
  logic [5:0]         w_add;
  logic [63:0]        w_len64;
  logic [511:0]       w_vec;

`ifdef SHA256_PAD_BYTESWAP_EN
  assign w_word = {bus.din_i[7:0], bus.din_i[15:8], bus.din_i[23:16], bus.din_i[31:24]};
`else
  assign w_word = bus.din_i;
`endif

  assign w_accept    = bus.din_valid_i & r_din_ready;
  assign w_bytes_sat = (bus.din_bytes_i > 3'd4) ? 3'd4 : bus.din_bytes_i;
  assign w_shift     = {w_bytes_sat[1:0], 3'b000};
  assign w_pad_word  = (w_word & ~(32'hFFFF_FFFF >> w_shift)) | (32'h8000_0000 >> w_shift);
  assign w_store     = (bus.din_last_i && (w_bytes_sat != 3'd4)) ? w_pad_word : w_word;
  assign w_add       = bus.din_last_i ? {w_bytes_sat, 3'b000} : 6'd32;
  assign w_len64     = 64'(r_bitlen);

  always_comb begin
    w_vec = '0;
    for (int n = 0; n < 16; n++) begin
      w_vec[(15-n)*32 +: 32] = r_words[n];
    end
  end

  assign bus.eng_vec_o   = w_vec;
  assign bus.eng_last_o  = r_last;
  assign bus.busy_o      = r_busy;
  assign bus.din_ready_o = r_din_ready;
  assign bus.eng_start_o = w_start;

  always_ff @(posedge clk_100mhz or posedge rst_i) begin
    if (rst_i) r_state <= S_FILL;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      S_FILL: begin
        if (w_accept) begin
          if (!bus.din_last_i)
            w_state_nxt = (r_idx[3:0] == 4'd15) ? S_ISSUE : S_FILL;
          else if (w_bytes_sat != 3'd4)
            w_state_nxt = S_PADZ;
          else
            w_state_nxt = (r_idx[3:0] == 4'd15) ? S_ISSUE : S_PAD0;
        end
      end
      S_PAD0: w_state_nxt = S_PADZ;
      S_PADZ: begin
        if (r_idx[4] || (r_idx[3:0] == 4'd15)) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (bus.eng_ready_i) begin
          w_start     = 1'b1;
          w_state_nxt = S_WAIT_LO;
        end
      end
      S_WAIT_LO: begin
        if (!bus.eng_ready_i) w_state_nxt = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (bus.eng_ready_i) begin
          case (r_after)
            A_PAD0:  w_state_nxt = S_PAD0;
            A_PADZ:  w_state_nxt = S_PADZ;
            default: w_state_nxt = S_FILL;
          endcase
        end
      end
      default: w_state_nxt = S_FILL;
    endcase
  end

  // r_len_here: the length words fit in the block currently being padded
  always_ff @(posedge clk_100mhz or posedge rst_i) begin
    if (rst_i) begin
      r_after     <= A_DONE;
      r_idx       <= '0;
      r_bitlen    <= '0;
      r_last      <= 1'b0;
      r_busy      <= 1'b0;
      r_din_ready <= 1'b0;
      r_len_here  <= 1'b0;
      for (int n = 0; n < 16; n++) r_words[n] <= '0;
    end else begin
      r_din_ready <= (w_state_nxt == S_FILL);
      case (r_state)
        S_FILL: begin
          if (w_accept) begin
            r_busy               <= 1'b1;
            r_bitlen             <= r_bitlen + LEN_W'(w_add);
            r_words[r_idx[3:0]]  <= w_store;
            r_idx                <= r_idx + 5'd1;
            if (!bus.din_last_i) begin
              if (r_idx[3:0] == 4'd15) r_after <= A_FILL;
            end else if (w_bytes_sat != 3'd4) begin
              r_len_here <= (r_idx < 5'd14);
            end else if (r_idx[3:0] == 4'd15) begin
              r_after <= A_PAD0;
            end
          end
        end
        S_PAD0: begin
          r_words[r_idx[3:0]] <= 32'h8000_0000;
          r_idx               <= r_idx + 5'd1;
          r_len_here          <= (r_idx < 5'd14);
        end
        S_PADZ: begin
          if (!r_idx[4]) begin
            if (r_len_here && (r_idx[3:0] == 4'd14))
              r_words[r_idx[3:0]] <= w_len64[63:32];
            else if (r_len_here && (r_idx[3:0] == 4'd15))
              r_words[r_idx[3:0]] <= w_len64[31:0];
            else
              r_words[r_idx[3:0]] <= 32'h0;
            r_idx <= r_idx + 5'd1;
          end
          if (r_idx[4] || (r_idx[3:0] == 4'd15)) begin
            r_last  <= r_len_here;
            r_after <= r_len_here ? A_DONE : A_PADZ;
          end
        end
        S_WAIT_HI: begin
          if (bus.eng_ready_i) begin
            r_idx <= '0;
            case (r_after)
              A_PADZ: r_len_here <= 1'b1;
              A_DONE: begin
                r_bitlen <= '0;
                r_last   <= 1'b0;
                r_busy   <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_padder.sv
// Scoreboard bench for sha256_padder: expected blocks queued at stimulus, checked on each start pulse.
module tb_sha256_padder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sha256_padder_if bus();

  sha256_padder #(.LEN_W(64)) dut (
    .clk_100mhz (clk),
    .rst_i      (rst),
    .bus        (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [511:0] q_vec [$];
  logic         q_last [$];
  logic [31:0]  tw [32];
  logic [31:0]  ew [16];
  logic [511:0] blk_hold;
  logic         hold = 1'b0;
  int           eng_cnt = 0;
  logic         eng_s;

  function automatic logic [511:0] pack_ew();
    logic [511:0] p;
    for (int n = 0; n < 16; n++) p[(15-n)*32 +: 32] = ew[n];
    return p;
  endfunction

  task automatic clr_ew();
    for (int n = 0; n < 16; n++) ew[n] = 32'h0;
  endtask

  task automatic push_exp(input logic l);
    q_vec.push_back(pack_ew());
    q_last.push_back(l);
  endtask

  task automatic chk_vec(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // engine model: drops ready for a few cycles after each start
  always @(posedge clk) begin
    eng_s = bus.eng_start_o;
    #1;
    if (rst)              eng_cnt = 0;
    else if (eng_s)       eng_cnt = 4;
    else if (eng_cnt > 0) eng_cnt = eng_cnt - 1;
    bus.eng_ready_i = (eng_cnt == 0) && !hold;
  end

  always @(negedge clk) begin
    if (!rst && bus.eng_start_o) begin
      if (q_vec.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_start act=1 exp=0");
      end else begin
        chk_vec("blk_vec", bus.eng_vec_o, q_vec.pop_front());
        chk("blk_last", 32'(bus.eng_last_o), 32'(q_last.pop_front()));
      end
    end
  end

  task automatic send(input logic [31:0] w, input logic l, input logic [2:0] b);
    bit ok;
    ok = 1'b0;
    bus.din_i       = w;
    bus.din_valid_i = 1'b1;
    bus.din_last_i  = l;
    bus.din_bytes_i = b;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (bus.din_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    bus.din_valid_i = 1'b0;
    bus.din_last_i  = 1'b0;
    bus.din_bytes_i = 3'd0;
    bus.din_i       = 32'h0;
    chk("send_accept", 32'(ok), 32'd1);
  endtask

  task automatic send_msg(input int n, input logic [2:0] lb, input bit fin);
    for (int i = 0; i < n; i++)
      send(tw[i], fin && (i == n-1), (fin && (i == n-1)) ? lb : 3'd0);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (q_vec.size() == 0 && !bus.busy_o && bus.eng_ready_i) break;
    end
    chk("done_queue", 32'(q_vec.size()), 32'd0);
    chk("done_busy", 32'(bus.busy_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    bus.din_i       = 32'h0;
    bus.din_valid_i = 1'b0;
    bus.din_last_i  = 1'b0;
    bus.din_bytes_i = 3'd0;
    bus.eng_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_din_ready", 32'(bus.din_ready_o), 32'd0);
    chk("rst_start", 32'(bus.eng_start_o), 32'd0);
    chk("rst_last", 32'(bus.eng_last_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk_vec("rst_vec", bus.eng_vec_o, 512'h0);
    @(posedge clk); #2 rst = 1'b0;

    // "abc"
    clr_ew(); ew[0] = 32'h6162_6380; ew[15] = 32'h18; push_exp(1'b1);
    tw[0] = 32'h6162_6300;
    send_msg(1, 3'd3, 1'b1);
    @(negedge clk);
    chk("busy_in_msg", 32'(bus.busy_o), 32'd1);
    wait_done();

    // empty message, junk data bits must be masked off
    clr_ew(); ew[0] = 32'h8000_0000; push_exp(1'b1);
    tw[0] = 32'hDEAD_BEEF;
    send_msg(1, 3'd0, 1'b1);
    wait_done();

    // 9 bytes, 0x80 mid-word
    clr_ew(); ew[0] = 32'h4142_4344; ew[1] = 32'h4546_4748; ew[2] = 32'h4980_0000; ew[15] = 32'h48;
    push_exp(1'b1);
    tw[0] = 32'h4142_4344; tw[1] = 32'h4546_4748; tw[2] = 32'h49FF_FFFF;
    send_msg(3, 3'd1, 1'b1);
    wait_done();

    // 56 bytes: 0x80 at word 14, length spills to a second block
    clr_ew();
    for (int i = 0; i < 14; i++) begin
      tw[i] = 32'h0001_0203 + 32'h0404_0404 * i;
      ew[i] = tw[i];
    end
    ew[14] = 32'h8000_0000; push_exp(1'b0);
    clr_ew(); ew[15] = 32'h1C0; push_exp(1'b1);
    send_msg(14, 3'd4, 1'b1);
    wait_done();

    // 64 bytes: full payload block, then 0x80 + length block
    clr_ew();
    for (int i = 0; i < 16; i++) begin
      tw[i] = 32'hA000_0000 + i;
      ew[i] = tw[i];
    end
    push_exp(1'b0);
    clr_ew(); ew[0] = 32'h8000_0000; ew[15] = 32'h200; push_exp(1'b1);
    send_msg(16, 3'd4, 1'b1);
    wait_done();

    // 61 bytes: 0x80 in word 15
    clr_ew();
    for (int i = 0; i < 15; i++) begin
      tw[i] = 32'h1111_0000 + i;
      ew[i] = tw[i];
    end
    tw[15] = 32'hABCD_EF12; ew[15] = 32'hAB80_0000; push_exp(1'b0);
    clr_ew(); ew[15] = 32'h1E8; push_exp(1'b1);
    send_msg(16, 3'd1, 1'b1);
    wait_done();

    // 52 bytes: 0x80 at word 13, length still fits
    clr_ew();
    for (int i = 0; i < 13; i++) begin
      tw[i] = 32'h2222_0000 + i;
      ew[i] = tw[i];
    end
    ew[13] = 32'h8000_0000; ew[15] = 32'h1A0; push_exp(1'b1);
    send_msg(13, 3'd4, 1'b1);
    wait_done();

    // bytes > 4 saturates to 4
    clr_ew(); ew[0] = 32'h6162_6364; ew[1] = 32'h8000_0000; ew[15] = 32'h20; push_exp(1'b1);
    tw[0] = 32'h6162_6364;
    send_msg(1, 3'd7, 1'b1);
    wait_done();

    // engine held busy after a full block
    hold = 1'b1;
    clr_ew();
    for (int i = 0; i < 16; i++) begin
      tw[i] = 32'h3333_0000 + i;
      ew[i] = tw[i];
    end
    blk_hold = pack_ew();
    push_exp(1'b0);
    clr_ew(); ew[0] = 32'h6162_6380; ew[15] = 32'h218; push_exp(1'b1);
    send_msg(16, 3'd0, 1'b0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("hold_start", 32'(bus.eng_start_o), 32'd0);
      chk("hold_din_ready", 32'(bus.din_ready_o), 32'd0);
      chk_vec("hold_vec", bus.eng_vec_o, blk_hold);
    end
    hold = 1'b0;
    send(32'h6162_6300, 1'b1, 3'd3);
    wait_done();

    // reset while padding
    tw[0] = 32'h1122_3300;
    send_msg(1, 3'd3, 1'b1);
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", 32'(bus.busy_o), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_din_ready", 32'(bus.din_ready_o), 32'd0);
    chk("mid_rst_start", 32'(bus.eng_start_o), 32'd0);
    chk("mid_rst_last", 32'(bus.eng_last_o), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy_o), 32'd0);
    chk_vec("mid_rst_vec", bus.eng_vec_o, 512'h0);
    @(posedge clk); #2 rst = 1'b0;
    clr_ew(); ew[0] = 32'h6162_6380; ew[15] = 32'h18; push_exp(1'b1);
    tw[0] = 32'h6162_6300;
    send_msg(1, 3'd3, 1'b1);
    wait_done();

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
